tagged_branch_predictor: RTL

Parametrised branch prediction unit for the fetch stage, replacing the single global 2-bit counter and the separate direct-mapped target buffer with one tagged table. Each entry holds a valid bit, a PC tag, a branch target and its own saturating direction counter. The fetch-stage PC is looked up combinationally in the same cycle. Resolved branches from execute update the table on the next clock edge. Optional performance counters record branch and misprediction totals.

---
 rtl/tagged_branch_predictor_if.sv | 22 ++
 rtl/tagged_branch_predictor.sv | 85 ++++++++
 2 files changed

// File: rtl/tagged_branch_predictor_if.sv
// tagged_branch_predictor_if: fetch lookup, execute update and statistics signals of the branch predictor.
interface tagged_branch_predictor_if;
    logic [31:0] PC_F;
    logic        Predict_Taken_F;
    logic [31:0] PC_Prediction_F;
    logic        Update_E;
    logic [31:0] PC_E;
    logic        Branch_Taken_E;
    logic [31:0] PC_Target_E;
    logic        Predict_Taken_E;
    logic [31:0] Branch_Count;
    logic [31:0] Mispredict_Count;

    modport master (
        output PC_F, Update_E, PC_E, Branch_Taken_E, PC_Target_E, Predict_Taken_E,
        input  Predict_Taken_F, PC_Prediction_F, Branch_Count, Mispredict_Count
    );
    modport slave (
        input  PC_F, Update_E, PC_E, Branch_Taken_E, PC_Target_E, Predict_Taken_E,
        output Predict_Taken_F, PC_Prediction_F, Branch_Count, Mispredict_Count
    );
endinterface

// File: rtl/tagged_branch_predictor.sv
// tagged_branch_predictor: tagged table of valid/tag/target/saturating counter, looked up combinationally.
// Defining TAGGED_BP_STATS_EN builds the resolved-branch and mispredict counters.
module tagged_branch_predictor #(
    parameter int ENTRIES = 32,
    parameter int CTR_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input logic CLK,
    input logic RST,
    tagged_branch_predictor_if.slave bp
);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    logic [ENTRIES-1:0]             valid_q;
    logic [ENTRIES-1:0][CTR_W-1:0]  ctr_q;
    logic [TAG_W-1:0]               tag_q [ENTRIES];
    logic [31:0]                    target_q [ENTRIES];

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e;
    logic [CTR_W-1:0] ctr_e, ctr_d;
    logic             unused_bits;

    assign idx_f = bp.PC_F[IDX_W+1:2];
    assign tag_f = bp.PC_F[31:IDX_W+2];
    assign idx_e = bp.PC_E[IDX_W+1:2];
    assign tag_e = bp.PC_E[31:IDX_W+2];
    assign unused_bits = ^{bp.PC_F[1:0], bp.PC_E[1:0]};

    // Outputs are forced quiet while RST is held, before the table has been cleared.
    assign hit_f = !RST && valid_q[idx_f] && tag_q[idx_f] == tag_f;
    assign bp.Predict_Taken_F = hit_f && ctr_q[idx_f][CTR_W-1];
    assign bp.PC_Prediction_F = hit_f ? target_q[idx_f] : 32'h0;

    always_comb begin
        hit_e = valid_q[idx_e] && tag_q[idx_e] == tag_e;
        ctr_e = ctr_q[idx_e];
        ctr_d = !hit_e ? CTR_WEAK
              : bp.Branch_Taken_E ? (ctr_e == CTR_MAX ? ctr_e : ctr_e + 1'b1)
              : (ctr_e == '0 ? ctr_e : ctr_e - 1'b1);
    end

    // Not-taken misses never allocate, so an aliasing not-taken branch leaves the owner intact.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            ctr_q   <= '0;
        end else if (bp.Update_E && (hit_e || bp.Branch_Taken_E)) begin
            valid_q[idx_e] <= 1'b1;
            ctr_q[idx_e]   <= ctr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && bp.Update_E && bp.Branch_Taken_E) begin
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= bp.PC_Target_E;
        end
    end

`ifdef TAGGED_BP_STATS_EN
    logic [31:0] br_cnt_q, mis_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (bp.Update_E) begin
            br_cnt_q  <= br_cnt_q + 32'd1;
            mis_cnt_q <= mis_cnt_q + 32'(bp.Predict_Taken_E != bp.Branch_Taken_E);
        end
    end

    assign bp.Branch_Count     = RST ? 32'h0 : br_cnt_q;
    assign bp.Mispredict_Count = RST ? 32'h0 : mis_cnt_q;
`else
    logic unused_pred;
    assign unused_pred         = bp.Predict_Taken_E;
    assign bp.Branch_Count     = 32'h0;
    assign bp.Mispredict_Count = 32'h0;
`endif
endmodule
